// File: rtl/dms_pkg.sv
// Shared types and default widths for the dms stimulus player.
package dms_pkg;

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned DLY_W_DEF = 16;
  localparam int unsigned FLAG_W    = 4;

  // Signal values applied by one program entry.
  typedef struct packed {
    logic c_oe;
    logic c;
    logic b;
    logic a;
  } flags_t;

  typedef struct packed {
    logic [DLY_W_DEF-1:0] dly;
    logic                 c_oe;
    logic                 c;
    logic                 b;
    logic                 a;
  } entry_t;

  typedef enum logic [1:0] {IDLE, COUNT, APPLY, FIN} state_t;

endpackage

// File: rtl/dms_stim_player_if.sv
// Host programming/control and stimulus output bundle of the stimulus player.
interface dms_stim_player_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DLY_W = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DLY_W+3:0] wr_data;
  logic [AW:0]      len;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             applied;
  logic [AW-1:0]    step_idx;
  logic             a;
  logic             b;
  logic             c_out;
  logic             c_oe;

  modport master (
    output wr_en, wr_addr, wr_data, len, start, abort,
    input  busy, done, applied, step_idx, a, b, c_out, c_oe
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, start, abort,
    output busy, done, applied, step_idx, a, b, c_out, c_oe
  );
endinterface

// File: rtl/dms_prog_mem.sv
// Program storage: one synchronous write port, one registered write-first read port.
module dms_prog_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 20,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_q;
  logic [W-1:0] rd_d;

  // Same-cycle write forwards so a write issued with start is seen by playback.
  always_comb begin
    rd_d = mem_q[raddr];
    if (we && (waddr == raddr)) rd_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rd_q <= rd_d;
  end

  assign rdata = rd_q;

endmodule

// File: rtl/dms_stim_player.sv
// Replays a host-loaded program of timed a/b/c updates, cycle-accurately, on start.
module dms_stim_player
  import dms_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  dms_stim_player_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned W  = DLY_W + FLAG_W;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    last_q, last_d;
  logic [AW-1:0]    step_q, step_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  flags_t           out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             applied_q, applied_d;

  logic             mem_we;
  logic [AW-1:0]    rd_addr;
  logic [W-1:0]     rd_data;
  logic [DLY_W-1:0] ent_dly;
  flags_t           ent_flags;

  assign mem_we = bus.wr_en && (state_q == IDLE);

  dms_prog_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign ent_dly   = rd_data[W-1:FLAG_W];
  assign ent_flags = flags_t'(rd_data[FLAG_W-1:0]);

  // The counter runs up to the current entry's dly, which is already valid on the
  // registered read port, so the next entry needs no extra fetch cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    applied_d = 1'b0;
    busy_d    = (state_q == COUNT) || (state_q == APPLY);
    done_d    = (state_q == FIN);
    rd_addr   = idx_q;

    unique case (state_q)
      IDLE: begin
        idx_d   = '0;
        rd_addr = '0;
        if (bus.start) begin
          cnt_d = '0;
          if (bus.len == '0) begin
            state_d = FIN;
          end else begin
            state_d = COUNT;
            last_d  = (bus.len > (AW+1)'(DEPTH)) ? AW'(DEPTH - 1)
                                                 : AW'(bus.len - (AW+1)'(1));
          end
        end
      end
      COUNT: begin
        if (bus.abort)              state_d = IDLE;
        else if (cnt_q == ent_dly)  state_d = APPLY;
        else                        cnt_d   = cnt_q + DLY_W'(1);
      end
      APPLY: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          out_d     = ent_flags;
          applied_d = 1'b1;
          step_d    = idx_q;
          rd_addr   = idx_q + AW'(1);
          if (idx_q == last_q) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + AW'(1);
            cnt_d   = '0;
            state_d = COUNT;
          end
        end
      end
      FIN: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      applied_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      applied_q <= applied_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.applied  = applied_q;
  assign bus.step_idx = step_q;
  assign bus.a        = out_q.a;
  assign bus.b        = out_q.b;
  assign bus.c_out    = out_q.c;
  assign bus.c_oe     = out_q.c_oe;

endmodule

// File: tb/tb_dms_stim_player.sv
// Scoreboard bench for dms_stim_player: stimulus pushes expected update/done events, a monitor checks them.
module tb_dms_stim_player;
  import dms_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DLY_W = DLY_W_DEF;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef struct {
    int         t;
    bit         is_done;
    logic [3:0] fl;
    int         idx;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dms_stim_player_if #(.DEPTH(DEPTH), .DLY_W(DLY_W)) bus ();
  dms_stim_player #(.DEPTH(DEPTH), .DLY_W(DLY_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  ev_t        q[$];
  entry_t     prog_m [DEPTH];
  logic [3:0] m_fl = 4'h0;
  int         m_idx = 0;
  bit         mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic entry_t mk(input int dly, input bit oe, input bit c, input bit b, input bit a);
    entry_t e;
    e.dly  = DLY_W'(dly);
    e.c_oe = oe;
    e.c    = c;
    e.b    = b;
    e.a    = a;
    return e;
  endfunction

  // Monitor: pops an event when its cycle comes, otherwise outputs must hold.
  always @(negedge clk) begin : mon
    ev_t e;
    if (rst_n && mon_en) begin
      if (q.size() > 0 && q[0].t == cyc) begin
        e = q.pop_front();
        if (e.is_done) begin
          check("done_pulse", 32'(bus.done), 32'd1);
          check("done_no_applied", 32'(bus.applied), 32'd0);
          check("done_busy_low", 32'(bus.busy), 32'd0);
        end else begin
          check("applied_pulse", 32'(bus.applied), 32'd1);
          check("applied_busy", 32'(bus.busy), 32'd1);
          m_fl  = e.fl;
          m_idx = e.idx;
        end
      end else begin
        check("no_applied", 32'(bus.applied), 32'd0);
        check("no_done", 32'(bus.done), 32'd0);
      end
      check("outputs", 32'({bus.c_oe, bus.c_out, bus.b, bus.a}), 32'(m_fl));
      check("step_idx", 32'(bus.step_idx), 32'(m_idx));
    end
  end

  task automatic wr(input int addr, input entry_t e);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = e;
    prog_m[addr] = e;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic push_sched(input int t0, input int n, input int n_push);
    int t = t0;
    for (int k = 0; k < n_push; k++) begin
      t = t + 2 + int'(prog_m[k].dly);
      q.push_back('{t, 1'b0, {prog_m[k].c_oe, prog_m[k].c, prog_m[k].b, prog_m[k].a}, k});
    end
    if (n_push == n) q.push_back('{t + 1, 1'b1, 4'h0, 0});
  endtask

  // Issues start; n_push < 0 expects the full run with done.
  task automatic play(input int len, input int n_push);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = (AW+1)'(len);
    n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    push_sched(cyc + 1, n, (n_push < 0) ? n : n_push);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((q.size() != 0 || bus.busy || bus.done) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", 32'(k < budget), 32'd1);
    check("queue_drained", 32'(q.size()), 32'd0);
    q.delete();
    @(negedge clk);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len = '0; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a", 32'(bus.a), 32'd0);
    check("rst_b", 32'(bus.b), 32'd0);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
    check("rst_c_float", 32'(bus.c_oe), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_applied", 32'(bus.applied), 32'd0);
    check("rst_step_idx", 32'(bus.step_idx), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Long delays; writes while idle must leave outputs untouched.
    wr(0, mk(99, 1, 1, 1, 0));
    wr(1, mk(99, 0, 0, 0, 1));
    wr(2, mk(99, 1, 0, 1, 1));
    play(3, -1);
    wait_idle(1000);

    // Zero delays, entry 0 written in the same cycle as start.
    wr(1, mk(0, 0, 1, 0, 1));
    wr(2, mk(0, 1, 1, 1, 0));
    wr(3, mk(0, 1, 0, 0, 0));
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = mk(0, 1, 1, 0, 0);
    prog_m[0] = mk(0, 1, 1, 0, 0);
    bus.start = 1'b1; bus.len = (AW+1)'(4);
    push_sched(cyc + 1, 4, 4);
    @(negedge clk);
    bus.wr_en = 1'b0; bus.start = 1'b0;
    wait_idle(200);

    play(0, -1);
    wait_idle(50);

    for (int k = 0; k < int'(DEPTH); k++) wr(k, mk(k % 3, k[0], k[1], ~k[0], k[2]));
    play(int'(DEPTH) + 3, -1);
    wait_idle(400);

    // Abort in COUNT after the second update, then restart.
    wr(0, mk(3, 1, 0, 1, 0));
    wr(1, mk(3, 1, 1, 0, 1));
    wr(2, mk(3, 0, 0, 1, 1));
    play(3, 2);
    repeat (11) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_idle(100);
    play(3, -1);
    wait_idle(100);

    // start and wr_en while busy are ignored; replay shows entry 0 intact.
    play(3, -1);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.len = (AW+1)'(1);
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = mk(7, 0, 1, 0, 0);
    @(negedge clk);
    bus.start = 1'b0; bus.wr_en = 1'b0;
    wait_idle(100);
    play(1, -1);
    wait_idle(100);

    // Asynchronous reset mid-COUNT.
    wr(0, mk(2, 1, 1, 1, 1));
    wr(1, mk(50, 0, 0, 0, 1));
    play(2, -1);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_a", 32'(bus.a), 32'd0);
    check("arst_b", 32'(bus.b), 32'd0);
    check("arst_c_out", 32'(bus.c_out), 32'd0);
    check("arst_c_float", 32'(bus.c_oe), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_step_idx", 32'(bus.step_idx), 32'd0);
    q.delete();
    m_fl = 4'h0;
    m_idx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    play(2, -1);
    wait_idle(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
